mem_stage: RTL

Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It holds the EX/MEM latch, drives the data-cache request handshake for loads and stores, and stalls the pipeline until the cache reports a hit. It also owns the MEM/WB latch that feeds writeback, passing register-write control through unchanged.

---
 rtl/mem_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage MIPS pipeline.
//   Holds the EX/MEM latch, runs the data-cache request handshake for loads
//   and stores, stalls upstream until the cache reports dhit, and owns the
//   MEM/WB latch that feeds writeback.
//
// Optional feature macro: MEM_WATCHDOG_EN
//   When defined, an ACCESS that waits TMO_CYC cycles without dhit is forced
//   to complete with zero load data and mem_err latches high until RST.
//   When undefined, mem_err is tied low and ACCESS waits indefinitely.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   en, flush                     pipeline advance / squash incoming instruction
//   ALUOut, rdat2, nPC            execute-stage data (address, store data, next PC)
//   dREN, dWEN, regWr, halt       execute-stage control
//   regSel [1:0], regDst [4:0]    writeback select / destination register
//   dmemREN, dmemWEN              cache request strobes
//   dmemaddr, dmemstore           cache address / store data
//   dhit, dmemload                cache completion / load data
//   mem_stall                     freeze upstream stages
//   *_wb                          MEM/WB latch outputs
//   mem_err                       sticky watchdog error
//
// State | meaning
// IDLE   | no memory op in EX/MEM, strobes low
// ACCESS | request driven, waiting for dhit
// HOLD   | access complete, pipeline held by en=0, strobes low

module mem_stage #(
  parameter int TMO_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] ALUOut,
  input  logic [31:0] rdat2,
  input  logic [31:0] nPC,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        regWr,
  input  logic        halt,
  input  logic [1:0]  regSel,
  input  logic [4:0]  regDst,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        mem_stall,
  output logic        regWr_wb,
  output logic        halt_wb,
  output logic [1:0]  regSel_wb,
  output logic [4:0]  regDst_wb,
  output logic [31:0] ALUOut_wb,
  output logic [31:0] ldata_wb,
  output logic [31:0] nPC_wb,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t      state_q, state_d;
  logic        adv, hit, tmo, load_mem;
  logic [31:0] ldata_q, ldata_now;

  logic [31:0] em_alu, em_rdat2, em_npc;
  logic        em_dren, em_dwen, em_regwr, em_halt;
  logic [1:0]  em_regsel;
  logic [4:0]  em_regdst;

`ifdef MEM_WATCHDOG_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
  logic [7:0] wd_cnt;
  logic       err_q;

  assign tmo = (state_q == ACCESS) & ~dhit & (wd_cnt == TMO_LIM);

  // Counter is held at zero outside ACCESS and on completion, so every
  // entry into ACCESS (including back-to-back re-entry) starts from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != ACCESS || hit) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + 8'd1;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign hit       = (state_q == ACCESS) & (dhit | tmo);
  assign mem_stall = (state_q == ACCESS) & ~(dhit | tmo);
  assign adv       = en & ~mem_stall;
  // A flushed instruction is latched with its memory controls cleared.
  assign load_mem  = adv & ~flush & (dREN | dWEN);

  assign dmemaddr  = em_alu;
  assign dmemstore = em_rdat2;

  // Load data seen by MEM/WB: the live bus on a real hit, zero on a forced
  // completion, otherwise the value captured earlier (HOLD exit).
  always_comb begin
    ldata_now = ldata_q;
    if (state_q == ACCESS && dhit) ldata_now = dmemload;
    else if (tmo)                  ldata_now = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    case (state_q)
      IDLE: begin
        if (adv) state_d = load_mem ? ACCESS : IDLE;
      end
      ACCESS: begin
        // Read+write together is treated as a store.
        dmemWEN = em_dwen;
        dmemREN = em_dren & ~em_dwen;
        if (hit) begin
          if (en) state_d = load_mem ? ACCESS : IDLE;
          else    state_d = HOLD;
        end
      end
      HOLD: begin
        if (en) state_d = load_mem ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      em_alu    <= '0;
      em_rdat2  <= '0;
      em_npc    <= '0;
      em_dren   <= 1'b0;
      em_dwen   <= 1'b0;
      em_regwr  <= 1'b0;
      em_halt   <= 1'b0;
      em_regsel <= '0;
      em_regdst <= '0;
    end else if (adv) begin
      em_alu    <= ALUOut;
      em_rdat2  <= rdat2;
      em_npc    <= nPC;
      em_dren   <= dREN  & ~flush;
      em_dwen   <= dWEN  & ~flush;
      em_regwr  <= regWr & ~flush;
      em_halt   <= halt  & ~flush;
      em_regsel <= regSel;
      em_regdst <= regDst;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ldata_q <= '0;
    else if (hit) ldata_q <= dhit ? dmemload : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regWr_wb  <= 1'b0;
      halt_wb   <= 1'b0;
      regSel_wb <= '0;
      regDst_wb <= '0;
      ALUOut_wb <= '0;
      ldata_wb  <= '0;
      nPC_wb    <= '0;
    end else if (adv) begin
      regWr_wb  <= em_regwr;
      halt_wb   <= em_halt;
      regSel_wb <= em_regsel;
      regDst_wb <= em_regdst;
      ALUOut_wb <= em_alu;
      ldata_wb  <= ldata_now;
      nPC_wb    <= em_npc;
    end
  end

endmodule
